// File: rtl/char_pixel_renderer.sv
// Character-to-pixel renderer: fetches characters, looks up glyph rows in a font ROM, streams AXI4-Stream pixels.
// Optional macro CHAR_PIXEL_RENDERER_SPACING_EN appends one background pixel to every glyph cell.
`timescale 1ns/1ps
module char_pixel_renderer #(
    parameter int FONT_WIDTH        = 5,
    parameter int FONT_HEIGHT       = 8,
    parameter int CHAR_IMAGE_WIDTH  = 80,
    parameter int CHAR_IMAGE_HEIGHT = 34,
    parameter int PIXEL_WIDTH       = 24,
    parameter int FONT_ADDR_WIDTH   = 8 + $clog2(FONT_HEIGHT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start_frame_stb,
    output logic                       o_read_frame_stb,
    output logic                       o_char_req_en,
    input  logic                       i_char_rdy,
    input  logic [7:0]                 i_char,
    output logic [FONT_ADDR_WIDTH-1:0] o_font_addr,
    input  logic [FONT_WIDTH-1:0]      i_font_data,
    input  logic [PIXEL_WIDTH-1:0]     i_fg_color,
    input  logic [PIXEL_WIDTH-1:0]     i_bg_color,
    output logic [PIXEL_WIDTH-1:0]     o_axis_tdata,
    output logic                       o_axis_tvalid,
    input  logic                       i_axis_tready,
    output logic                       o_axis_tuser,
    output logic                       o_axis_tlast,
    output logic                       o_busy,
    output logic                       o_frame_done_stb
);

`ifdef CHAR_PIXEL_RENDERER_SPACING_EN
    localparam int CELL_W = FONT_WIDTH + 1;
`else
    localparam int CELL_W = FONT_WIDTH;
`endif
    localparam int PIX_W  = $clog2(CELL_W + 1);
    localparam int COL_W  = (CHAR_IMAGE_WIDTH > 1)  ? $clog2(CHAR_IMAGE_WIDTH)  : 1;
    localparam int ROW_W  = (FONT_HEIGHT > 1)       ? $clog2(FONT_HEIGHT)       : 1;
    localparam int LINE_W = (CHAR_IMAGE_HEIGHT > 1) ? $clog2(CHAR_IMAGE_HEIGHT) : 1;

    localparam logic [PIX_W-1:0]  PIX_LAST  = PIX_W'(CELL_W - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(CHAR_IMAGE_WIDTH - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST  = ROW_W'(FONT_HEIGHT - 1);
    localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(CHAR_IMAGE_HEIGHT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_CHAR,
        S_FONT_WAIT,
        S_FONT_LATCH,
        S_EMIT
    } state_t;

    state_t                     r_state;
    state_t                     w_next;
    logic                       r_read_frame_stb;
    logic                       r_char_req_en;
    logic [FONT_ADDR_WIDTH-1:0] r_font_addr;
    logic [FONT_WIDTH-1:0]      r_shift;
    logic [PIX_W-1:0]           r_pix_cnt;
    logic [COL_W-1:0]           r_col;
    logic [ROW_W-1:0]           r_font_row;
    logic [LINE_W-1:0]          r_line;
    logic                       r_sof;
    logic                       r_tvalid;
    logic                       r_done_stb;

    logic w_accept;
    logic w_pix_last;
    logic w_cell_end;
    logic w_col_last;
    logic w_row_last;
    logic w_line_last;
    logic w_frame_end;
    logic w_pix_set;

    assign w_accept    = r_tvalid & i_axis_tready;
    assign w_pix_last  = (r_pix_cnt == PIX_LAST);
    assign w_cell_end  = w_accept & w_pix_last;
    assign w_col_last  = (r_col == COL_LAST);
    assign w_row_last  = (r_font_row == ROW_LAST);
    assign w_line_last = (r_line == LINE_LAST);
    assign w_frame_end = w_cell_end & w_col_last & w_row_last & w_line_last;

`ifdef CHAR_PIXEL_RENDERER_SPACING_EN
    // The trailing spacing pixel is background regardless of what the shifter holds.
    assign w_pix_set = r_shift[FONT_WIDTH-1] & (r_pix_cnt != PIX_W'(FONT_WIDTH));
`else
    assign w_pix_set = r_shift[FONT_WIDTH-1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:       if (i_start_frame_stb) w_next = S_REQ_CHAR;
            S_REQ_CHAR:   if (i_char_rdy) w_next = S_FONT_WAIT;
            S_FONT_WAIT:  w_next = S_FONT_LATCH;
            S_FONT_LATCH: w_next = S_EMIT;
            S_EMIT:       if (w_cell_end) w_next = w_frame_end ? S_IDLE : S_REQ_CHAR;
            default:      w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_read_frame_stb <= 1'b0;
            r_char_req_en    <= 1'b0;
            r_font_addr      <= '0;
            r_shift          <= '0;
            r_pix_cnt        <= '0;
            r_col            <= '0;
            r_font_row       <= '0;
            r_line           <= '0;
            r_sof            <= 1'b0;
            r_tvalid         <= 1'b0;
            r_done_stb       <= 1'b0;
        end else begin
            r_read_frame_stb <= 1'b0;
            r_done_stb       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start_frame_stb) begin
                        r_read_frame_stb <= 1'b1;
                        r_char_req_en    <= 1'b1;
                        r_col            <= '0;
                        r_font_row       <= '0;
                        r_line           <= '0;
                        r_sof            <= 1'b1;
                    end
                end
                S_REQ_CHAR: begin
                    // Request stays up until the buffer answers, then drops on that edge to avoid a second fetch.
                    if (i_char_rdy) begin
                        r_char_req_en <= 1'b0;
                        r_font_addr   <= FONT_ADDR_WIDTH'({i_char, r_font_row});
                    end
                end
                S_FONT_LATCH: begin
                    r_shift   <= i_font_data;
                    r_pix_cnt <= '0;
                    r_tvalid  <= 1'b1;
                end
                S_EMIT: begin
                    if (w_accept) begin
                        r_shift   <= r_shift << 1;
                        r_pix_cnt <= r_pix_cnt + PIX_W'(1);
                        r_sof     <= 1'b0;
                    end
                    if (w_cell_end) begin
                        r_tvalid <= 1'b0;
                        if (w_col_last) begin
                            r_col <= '0;
                            if (w_row_last) begin
                                r_font_row <= '0;
                                r_line     <= w_line_last ? '0 : r_line + LINE_W'(1);
                            end else begin
                                r_font_row <= r_font_row + ROW_W'(1);
                            end
                        end else begin
                            r_col <= r_col + COL_W'(1);
                        end
                        if (w_frame_end) begin
                            r_done_stb <= 1'b1;
                        end else begin
                            r_char_req_en <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_read_frame_stb = r_read_frame_stb;
    assign o_char_req_en    = r_char_req_en;
    assign o_font_addr      = r_font_addr;
    assign o_axis_tvalid    = r_tvalid;
    assign o_axis_tdata     = r_tvalid ? (w_pix_set ? i_fg_color : i_bg_color) : '0;
    assign o_axis_tuser     = r_sof & r_tvalid;
    assign o_axis_tlast     = r_tvalid & w_col_last & w_pix_last;
    assign o_busy           = (r_state != S_IDLE);
    assign o_frame_done_stb = r_done_stb;

endmodule

// File: doc/char_pixel_renderer.md
Name: char_pixel_renderer

Overview:
- Sits directly downstream of the on-screen-display character buffer and converts its character stream into an AXI4-Stream pixel raster.
- Per frame it strobes the buffer's read-frame input and requests characters one at a time through the buffer's request/ready pair.
- Each character is looked up in an external font ROM and shifted out as FONT_WIDTH foreground/background pixels.
- The buffer delivers each text row FONT_HEIGHT times, one font row per pass; the renderer tracks column, font row and text line itself.

Parameters:
- FONT_WIDTH, 5, pixels per glyph row (font ROM data width).
- FONT_HEIGHT, 8, glyph rows; must be a power of 2.
- CHAR_IMAGE_WIDTH, 80, characters per text line.
- CHAR_IMAGE_HEIGHT, 34, text lines per frame.
- PIXEL_WIDTH, 24, colour width.
- FONT_ADDR_WIDTH, 8 + clog2(FONT_HEIGHT) = 11, font ROM address width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- i_start_frame_stb  in  1  begin rendering one frame
- o_read_frame_stb  out  1  to char buffer i_read_frame_stb
- o_char_req_en  out  1  to char buffer i_char_req_en
- i_char_rdy  in  1  from char buffer o_char_rdy
- i_char  in  8  from char buffer o_char; valid only while i_char_rdy=1
- o_font_addr  out  FONT_ADDR_WIDTH  {char, font_row}
- i_font_data  in  FONT_WIDTH  glyph row, MSB = leftmost pixel
- i_fg_color  in  PIXEL_WIDTH  pixel colour for a set glyph bit
- i_bg_color  in  PIXEL_WIDTH  pixel colour for a clear glyph bit
- o_axis_tdata  out  PIXEL_WIDTH  pixel
- o_axis_tvalid  out  1  pixel valid
- i_axis_tready  in  1  sink ready
- o_axis_tuser  out  1  start of frame; first pixel only
- o_axis_tlast  out  1  last pixel of each pixel row
- o_busy  out  1  frame in progress
- o_frame_done_stb  out  1  one-cycle pulse after the final pixel is accepted

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: every output is 0; state is IDLE; all counters are 0. Reset asserted mid-frame abandons the frame immediately, with no done pulse.
- States: IDLE, REQ_CHAR, FONT_WAIT, FONT_LATCH, EMIT.
- IDLE:
  - On i_start_frame_stb: pulse o_read_frame_stb for 1 cycle, clear col/row/line counters, set the sof flag, go to REQ_CHAR.
  - i_start_frame_stb is ignored in any other state.
- REQ_CHAR:
  - o_char_req_en is registered high and held until i_char_rdy is sampled high.
  - On that edge: req drops, o_font_addr <= {i_char, font_row}, go to FONT_WAIT.
  - Holding req until ready guarantees the buffer's GET_CHAR state sees it; dropping on the same edge prevents a double fetch.
- FONT_WAIT: 1 cycle (synchronous ROM latency).
- FONT_LATCH: latch i_font_data into the shift register, clear the pixel counter, assert tvalid, go to EMIT.
  - Character-in to first tvalid = 2 edges after the i_char_rdy edge.
- EMIT:
  - tdata = shift MSB ? i_fg_color : i_bg_color.
  - tdata, tuser and tlast stay stable while tvalid=1 and tready=0.
  - On tvalid & tready: shift left, increment the pixel counter, clear the sof flag.
  - After the last pixel of the cell is accepted: tvalid drops.
    - col < CHAR_IMAGE_WIDTH-1: col+1.
    - Otherwise col=0, and font_row+1 with wrap to 0 and line+1.
    - If line wraps past CHAR_IMAGE_HEIGHT-1: pulse o_frame_done_stb and go to IDLE; otherwise go to REQ_CHAR.
- tuser = sof flag & tvalid.
- tlast = tvalid & (col == CHAR_IMAGE_WIDTH-1) & (last pixel of cell).
- Counts per frame: CHAR_IMAGE_WIDTH*FONT_HEIGHT*CHAR_IMAGE_HEIGHT character fetches (21760 at defaults); 272 rows of 400 pixels.
- Counter widths hold their maxima with no overflow.
- o_busy = (state != IDLE).
- i_fg_color and i_bg_color are sampled per pixel, so a change mid-frame takes effect on the next emitted pixel.

Optional Feature:
- Macro: CHAR_PIXEL_RENDERER_SPACING_EN.
- Defined: each cell emits FONT_WIDTH+1 pixels; the extra rightmost pixel is always i_bg_color. A row is 480 pixels at defaults, and tlast moves to the spacing pixel of the last column.
- Undefined: FONT_WIDTH pixels per cell, 400 per row.

Test Plan:
- Reset, then idle: all outputs 0; i_start_frame_stb -> o_read_frame_stb high exactly 1 cycle, o_busy=1 from the next cycle.
- Char 0x41 at row 0, i_font_data=5'b10110 (fg=0xFFFFFF, bg=0x000000), tready=1 -> pixels FFFFFF,000000,FFFFFF,FFFFFF,000000; tuser on the first pixel only.
- i_char_rdy delayed 5 cycles after req -> o_char_req_en stays high 5 cycles and drops the edge after rdy; exactly one fetch.
- tready toggled 1-0-0-1 during EMIT -> tdata/tlast held stable; no pixel lost or duplicated.
- Params WIDTH=2, HEIGHT=1, FONT_HEIGHT=2 -> font_addr row bits 0,0,1,1; tlast on pixels 10 and 20; 4 fetches; done pulse after the 20th accept.
- rst asserted mid-EMIT -> next cycle tvalid=0, req=0, o_busy=0, no done pulse; a new start renders from col/row/line 0.
- Spacing macro defined -> 6 pixels per cell, 6th = bg, tlast at pixel 480.
